conv3x3_mac: RTL and testbench

- Downstream consumer of the 3x3 window line buffer. Takes its 72-bit window and window-valid strobe, applies a runtime-loadable signed 3x3 kernel, and emits one rounded, shifted, saturated 8-bit output pixel per valid window.
- Three-stage pipeline that advances on the same ena as the window buffer.
- Coefficients are loaded serially by the host before or between frames.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_kernel_regs.sv | 48 ++++
 rtl/conv3x3_mac.sv | 80 ++++++++
 tb/tb_conv3x3_mac.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution datapath.
//   PIX_W  - pixel width (unsigned)
//   KTAPS  - number of window taps
//   PROD_W - width of one pixel x coefficient product for the default 8-bit kernel
//   WIN_W  - width of the flat window bus
//   get_tap - extract tap k (k = 3*row + col) from the row-major window bus
//   sat_u8  - clamp a signed value into the unsigned 8-bit pixel range
package conv_pkg;
  localparam int PIX_W  = 8;
  localparam int KTAPS  = 9;
  localparam int PROD_W = 17;
  localparam int WIN_W  = PIX_W * KTAPS;

  // r00 sits in the top byte, r22 in the bottom byte.
  function automatic logic [PIX_W-1:0] get_tap(input logic [WIN_W-1:0] m, input int k);
    return m[WIN_W-1-PIX_W*k -: PIX_W];
  endfunction

  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [31:0] v);
    if (v < 0)
      return '0;
    else if (v > 32'sd255)
      return 8'hFF;
    else
      return v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/conv_kernel_regs.sv
// conv_kernel_regs: serially loaded 3x3 coefficient store.
//   clock, reset  - rising-edge clock, async active-high reset
//   k_load        - write strobe; writes k_data at the current index, then advances it
//   k_data        - signed coefficient value
//   coefs         - flat bus, coef[k] at [k*KW +: KW]
//   kernel_ready  - all nine coefficients written since the last restart at index 0
module conv_kernel_regs
  import conv_pkg::*;
#(
  parameter int KW = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 k_load,
  input  logic signed [KW-1:0] k_data,
  output logic [KTAPS*KW-1:0]  coefs,
  output logic                 kernel_ready
);

  localparam logic [3:0] LAST_IDX = 4'(KTAPS - 1);

  logic signed [KW-1:0] coef [KTAPS];
  logic [3:0]           k_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < KTAPS; k++) coef[k] <= '0;
      k_idx        <= '0;
      kernel_ready <= 1'b0;
    end else if (k_load) begin
      for (int k = 0; k < KTAPS; k++)
        if (k_idx == 4'(k)) coef[k] <= k_data;
      if (k_idx == LAST_IDX) begin
        k_idx        <= '0;
        kernel_ready <= 1'b1;
      end else begin
        k_idx <= k_idx + 4'd1;
        // Starting a fresh load invalidates the kernel until the 9th write lands.
        if (k_idx == 4'd0) kernel_ready <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < KTAPS; g++) begin : g_flat
    assign coefs[g*KW +: KW] = coef[g];
  end

endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3-stage signed 3x3 MAC producing one saturated 8-bit pixel per window.
//   clock, reset   - rising-edge clock, async active-high reset
//   ena            - pipeline advance; every stage holds when low
//   matrix         - 72-bit row-major window of unsigned pixels (r00 in the top byte)
//   conv_valid     - matrix carries a valid window
//   k_load, k_data - serial coefficient load, independent of ena
//   kernel_ready   - full kernel present; windows are only accepted while high
//   pix_out        - result pixel, holds between results
//   pix_valid      - pix_out is a new result this ena cycle
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int KW    = 8,
  parameter int SHIFT = 4,
  parameter int ACC_W = 21
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [WIN_W-1:0]     matrix,
  input  logic                 conv_valid,
  input  logic                 k_load,
  input  logic signed [KW-1:0] k_data,
  output logic                 kernel_ready,
  output logic [PIX_W-1:0]     pix_out,
  output logic                 pix_valid
);

  localparam int P_W = PIX_W + 1 + KW;
  // Round-half-up constant; the inner guard keeps the shift amount legal when SHIFT=0.
  localparam int RND = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;

  logic [KTAPS*KW-1:0] coefs;

  conv_kernel_regs #(.KW(KW)) u_kregs (
    .clock        (clock),
    .reset        (reset),
    .k_load       (k_load),
    .k_data       (k_data),
    .coefs        (coefs),
    .kernel_ready (kernel_ready)
  );

  logic                    accept;
  logic signed [P_W-1:0]   prod    [KTAPS];
  logic signed [ACC_W-1:0] row_sum [3];
  logic                    v1, v2, v3;
  logic signed [ACC_W-1:0] sum_s3, rounded, shifted;

  // ena is applied in the register block; the coefficient bus seen here is the
  // pre-write value, so a same-cycle k_load never affects the accepted window.
  assign accept  = conv_valid & kernel_ready;
  assign sum_s3  = row_sum[0] + row_sum[1] + row_sum[2];
  assign rounded = sum_s3 + ACC_W'(RND);
  assign shifted = rounded >>> SHIFT;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < KTAPS; k++) prod[k] <= '0;
      for (int r = 0; r < 3; r++) row_sum[r] <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      pix_out <= '0;
    end else if (ena) begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      for (int k = 0; k < KTAPS; k++)
        prod[k] <= P_W'($signed({1'b0, get_tap(matrix, k)})) *
                   P_W'($signed(coefs[k*KW +: KW]));
      for (int r = 0; r < 3; r++)
        row_sum[r] <= ACC_W'(prod[3*r]) + ACC_W'(prod[3*r+1]) + ACC_W'(prod[3*r+2]);
      if (v2) pix_out <= sat_u8(32'(shifted));
    end
  end

  assign pix_valid = v3;

endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed self-checking bench for conv3x3_mac (SHIFT=4).
module tb_conv3x3_mac;

  logic              clock;
  logic              reset;
  logic              ena;
  logic [71:0]       matrix;
  logic              conv_valid;
  logic              k_load;
  logic signed [7:0] k_data;
  logic              kernel_ready;
  logic [7:0]        pix_out;
  logic              pix_valid;

  int n_cmp;
  int n_bad;
  int res_q[$];
  int kbuf[9];

  conv3x3_mac #(.KW(8), .SHIFT(4), .ACC_W(21)) dut (
    .clock        (clock),
    .reset        (reset),
    .ena          (ena),
    .matrix       (matrix),
    .conv_valid   (conv_valid),
    .k_load       (k_load),
    .k_data       (k_data),
    .kernel_ready (kernel_ready),
    .pix_out      (pix_out),
    .pix_valid    (pix_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // A result is consumed once: in the ena cycle where pix_valid is high.
  always @(negedge clock)
    if (!reset && pix_valid && ena) res_q.push_back(int'(pix_out));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic load_kbuf();
    for (int k = 0; k < 9; k++) begin
      k_load = 1'b1;
      k_data = 8'(kbuf[k]);
      tick();
    end
    k_load = 1'b0;
  endtask

  task automatic load_kernel(input int centre, input int others);
    for (int k = 0; k < 9; k++) kbuf[k] = (k == 4) ? centre : others;
    load_kbuf();
  endtask

  task automatic send(input logic [71:0] m);
    conv_valid = 1'b1;
    matrix     = m;
    tick();
    conv_valid = 1'b0;
  endtask

  function automatic logic [71:0] win_c(input int centre, input int others);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[71-8*k -: 8] = 8'((k == 4) ? centre : others);
    return w;
  endfunction

  function automatic logic [71:0] win_lin(input int base, input int step);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[71-8*k -: 8] = 8'(base + step * k);
    return w;
  endfunction

  function automatic logic [71:0] win_rand(input int centre);
    logic [71:0] w;
    w = {8'($urandom), 32'($urandom), 32'($urandom)};
    w[39:32] = 8'(centre);
    return w;
  endfunction

  function automatic int pop_res();
    if (res_q.size() == 0) return -1;
    return res_q.pop_front();
  endfunction

  initial begin
    int i;
    int c;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    ena = 1'b1;
    conv_valid = 1'b0;
    k_load = 1'b0;
    k_data = '0;
    matrix = '0;
    drain(2);
    chk("reset_pix_out", int'(pix_out), 0);
    chk("reset_pix_valid", int'(pix_valid), 0);
    chk("reset_kernel_ready", int'(kernel_ready), 0);
    reset = 1'b0;
    tick();

    // window before any kernel is dropped
    send(win_c(200, 200));
    drain(5);
    chk("drop_no_kernel", res_q.size(), 0);

    // identity kernel, ready only after the 9th write
    for (int k = 0; k < 9; k++) begin
      k_load = 1'b1;
      k_data = 8'((k == 4) ? 16 : 0);
      tick();
      if (k == 7) chk("ready_after_8_writes", int'(kernel_ready), 0);
    end
    k_load = 1'b0;
    chk("ready_after_9_writes", int'(kernel_ready), 1);

    // latency: valid exactly on the 3rd ena edge after acceptance
    send(win_rand(8'h5A));
    chk("latency_edge1", int'(pix_valid), 0);
    tick();
    chk("latency_edge2", int'(pix_valid), 0);
    tick();
    chk("latency_edge3", int'(pix_valid), 1);
    chk("identity_pix", int'(pix_out), 8'h5A);

    // stall holds output and valid; release consumes it once
    ena = 1'b0;
    drain(2);
    chk("stall_hold_valid", int'(pix_valid), 1);
    chk("stall_hold_pix", int'(pix_out), 8'h5A);
    ena = 1'b1;
    tick();
    chk("post_stall_valid", int'(pix_valid), 0);
    chk("pix_holds_when_invalid", int'(pix_out), 8'h5A);
    chk("stall_single_capture", res_q.size(), 1);
    res_q.delete();

    // stream of 4 windows under ena pattern 1,0,0,1
    i = 0;
    c = 0;
    while (i < 4) begin
      ena = ((c % 4) == 0 || (c % 4) == 3);
      conv_valid = 1'b1;
      matrix = win_rand(10 * (i + 1));
      tick();
      if (ena) i++;
      c++;
    end
    conv_valid = 1'b0;
    ena = 1'b1;
    drain(5);
    chk("stream_count", res_q.size(), 4);
    chk("stream_res0", pop_res(), 10);
    chk("stream_res1", pop_res(), 20);
    chk("stream_res2", pop_res(), 30);
    chk("stream_res3", pop_res(), 40);

    // all ones, all 255: (2295+8)>>4 = 143
    load_kernel(1, 1);
    send(win_c(255, 255));
    drain(4);
    chk("ones_255", pop_res(), 143);

    // all -1, taps 10: -90 saturates to 0
    load_kernel(-1, -1);
    send(win_c(10, 10));
    drain(4);
    chk("neg_sat_zero", pop_res(), 0);

    // centre 127: 255 -> 2024 saturates to 255; 3 -> (381+8)>>4 = 24 (rounding)
    load_kernel(127, 0);
    send(win_c(255, 0));
    send(win_c(3, 9));
    drain(4);
    chk("pos_sat_255", pop_res(), 255);
    chk("round_centre3", pop_res(), 24);

    // asymmetric kernel coef[k]=k-2 with taps 10*(k+1): sum 1500 -> (1508)>>4 = 94
    for (int k = 0; k < 9; k++) kbuf[k] = k - 2;
    load_kbuf();
    send(win_lin(10, 10));
    drain(4);
    chk("tap_order_lin", pop_res(), 94);

    // reload: window accepted with first write uses old kernel
    load_kernel(16, 0);
    res_q.delete();
    k_load = 1'b1;
    k_data = 8'sd1;
    conv_valid = 1'b1;
    matrix = win_c(100, 50);
    tick();
    k_load = 1'b0;
    conv_valid = 1'b0;
    chk("reload_ready_low", int'(kernel_ready), 0);
    send(win_c(200, 200));
    for (int k = 1; k < 9; k++) begin
      k_load = 1'b1;
      k_data = 8'sd1;
      tick();
    end
    k_load = 1'b0;
    chk("reload_ready_high", int'(kernel_ready), 1);
    send(win_c(16, 16));
    drain(5);
    chk("reload_count", res_q.size(), 2);
    chk("reload_old_kernel", pop_res(), 100);
    chk("reload_new_kernel", pop_res(), 9);

    // async reset with windows in flight
    res_q.delete();
    send(win_c(16, 16));
    send(win_c(16, 16));
    send(win_c(16, 16));
    chk("pre_reset_valid", int'(pix_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", int'(pix_valid), 0);
    chk("async_reset_pix", int'(pix_out), 0);
    chk("async_reset_ready", int'(kernel_ready), 0);
    #3;
    reset = 1'b0;
    tick();
    send(win_c(16, 16));
    send(win_c(16, 16));
    send(win_c(16, 16));
    drain(5);
    chk("post_reset_no_output", res_q.size(), 0);
    chk("post_reset_valid_low", int'(pix_valid), 0);
    load_kernel(1, 1);
    send(win_c(16, 16));
    drain(4);
    chk("post_reset_reload", pop_res(), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
